// File: rtl/pixel_write_master.sv
// Pixel write master. Takes pixels from the core over the data_ready/data_sent
// handshake, queues them in a small FIFO, and drains them to the SDRAM frame
// buffer as single-beat Avalon-MM writes. Each pixel goes to one of two frame bases.
module pixel_write_master #(
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] FB0_BASE   = 32'h0000_0000,
    parameter logic [31:0] FB1_BASE   = 32'h0010_0000,
    parameter int          MAX_PIXELS = 307200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_ready,
    input  logic [18:0] address,
    input  logic [15:0] color,
    input  logic        frame_target,
    output logic        data_sent,
    output logic [31:0] avm_address,
    output logic        avm_write,
    output logic [15:0] avm_writedata,
    output logic [1:0]  avm_byteenable,
    input  logic        avm_waitrequest,
    output logic        idle,
    output logic        range_err
);

    localparam int             PW      = $clog2(FIFO_DEPTH);
    localparam int             CW      = PW + 1;
    localparam logic [CW-1:0]  DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [18:0]    MAX_C   = 19'(MAX_PIXELS);

    typedef enum logic {ST_IDLE, ST_WRITE} state_t;

    // FIFO entry layout: {frame_target, address, color}
    logic [35:0]   fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;

    state_t        state_reg;
    logic          data_sent_reg;
    logic          range_err_reg;
    logic [31:0]   avm_address_reg;
    logic          avm_write_reg;
    logic [15:0]   avm_writedata_reg;
    logic [1:0]    avm_byteenable_reg;

    logic          req_valid;
    logic          in_range;
    logic          pop_en;
    logic          push_en;
    logic          drop_en;
    logic [35:0]   head_entry;
    logic [31:0]   head_address;

    // Handshake decode. A pending data_sent pulse masks the request so the same
    // pixel is never captured twice. A pop frees a slot for a same-edge push.
    // Out-of-range pixels are acknowledged even when the FIFO is full.
    always_comb begin
        req_valid    = data_ready && !data_sent_reg;
        in_range     = (address < MAX_C);
        pop_en       = (count_reg != '0) && ((state_reg == ST_IDLE) || !avm_waitrequest);
        push_en      = req_valid && in_range && ((count_reg != DEPTH_C) || pop_en);
        drop_en      = req_valid && !in_range;
        head_entry   = fifo_mem[rd_ptr_reg];
        head_address = (head_entry[35] ? FB1_BASE : FB0_BASE)
                     + {12'b0, head_entry[34:16], 1'b0};
    end

    // FIFO storage. It has no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr_reg] <= {frame_target, address, color};
        end
    end

    // FIFO pointers and occupancy. The pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop_en)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Acknowledge pulse and the sticky range error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_sent_reg <= 1'b0;
            range_err_reg <= 1'b0;
        end else begin
            data_sent_reg <= push_en || drop_en;
            range_err_reg <= range_err_reg || drop_en;
        end
    end

    // Write FSM. The bus outputs are loaded on each pop and held during stalls.
    // A completing write chains directly into the next one when the FIFO has data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            avm_write_reg      <= 1'b0;
            avm_address_reg    <= '0;
            avm_writedata_reg  <= '0;
            avm_byteenable_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pop_en) begin
                        avm_address_reg    <= head_address;
                        avm_writedata_reg  <= head_entry[15:0];
                        avm_byteenable_reg <= 2'b11;
                        avm_write_reg      <= 1'b1;
                        state_reg          <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!avm_waitrequest) begin
                        if (pop_en) begin
                            avm_address_reg    <= head_address;
                            avm_writedata_reg  <= head_entry[15:0];
                            avm_byteenable_reg <= 2'b11;
                            avm_write_reg      <= 1'b1;
                        end else begin
                            avm_write_reg      <= 1'b0;
                            avm_byteenable_reg <= 2'b00;
                            state_reg          <= ST_IDLE;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign data_sent      = data_sent_reg;
    assign range_err      = range_err_reg;
    assign avm_address    = avm_address_reg;
    assign avm_write      = avm_write_reg;
    assign avm_writedata  = avm_writedata_reg;
    assign avm_byteenable = avm_byteenable_reg;
    assign idle           = (count_reg == '0) && (state_reg == ST_IDLE) && !data_ready;

endmodule
